// File: rtl/instruction_cache_controller.sv
// Direct-mapped read-only instruction cache (8 x 16-byte lines) with a single
// outstanding block refill from instruction memory and a saturating miss counter.
module instruction_cache_controller #(
   parameter int MISS_CNT_W = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpu_read,
   input  logic [31:0]           pc,
   output logic [31:0]           instruction,
   output logic                  cpu_busywait,
   output logic                  mem_read,
   output logic [27:0]           mem_address,
   input  logic [127:0]          mem_readdata,
   input  logic                  mem_busywait,
   output logic [MISS_CNT_W-1:0] miss_count
);

   typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

   state_t                r_state;
   logic [7:0]            r_valid;
   logic [24:0]           r_tag  [0:7];
   logic [127:0]          r_data [0:7];
   logic [127:0]          r_fill;
   logic [27:0]           r_addr;
   logic                  r_mem_read;
   logic [MISS_CNT_W-1:0] r_miss_cnt;

   logic [2:0]            w_idx;
   logic [1:0]            w_word;
   logic                  w_hit;
   logic                  w_miss;
   logic [2:0]            w_fill_idx;

   assign w_idx      = pc[6:4];
   assign w_word     = pc[3:2];
   assign w_hit      = cpu_read & r_valid[w_idx] & (r_tag[w_idx] == pc[31:7]);
   assign w_miss     = cpu_read & ~w_hit;
   assign w_fill_idx = r_addr[2:0];

   assign instruction  = w_hit ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'h0;
   assign cpu_busywait = cpu_read & ((r_state != IDLE) | ~w_hit);
   assign mem_read     = r_mem_read;
   assign mem_address  = r_addr;
   assign miss_count   = r_miss_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_mem_read <= 1'b0;
         r_addr     <= '0;
         r_valid    <= '0;
         r_miss_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_addr     <= pc[31:4];
                  r_mem_read <= 1'b1;
                  if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + MISS_CNT_W'(1);
                  r_state    <= MEM_READ;
               end
            end
            MEM_READ: begin
               if (!mem_busywait) begin
                  r_mem_read <= 1'b0;
                  r_state    <= UPDATE;
               end
            end
            UPDATE: begin
               r_valid[w_fill_idx] <= 1'b1;
               r_state             <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Tag/data storage is not reset; the valid bit alone guards it, so an
   // UPDATE cut short by reset leaves nothing observable.
   always_ff @(posedge clock) begin
      if (r_state == MEM_READ && !mem_busywait) r_fill <= mem_readdata;
      if (r_state == UPDATE && !reset) begin
         r_data[w_fill_idx] <= r_fill;
         r_tag[w_fill_idx]  <= r_addr[27:3];
      end
   end

endmodule

// File: tb/tb_instruction_cache_controller.sv
// Randomized self-checking bench: a line/tag model of the cache plus a latency-
// programmable block memory; a second instance with a 2-bit counter checks saturation.
module tb_instruction_cache_controller;

   logic          clock = 1'b0;
   logic          reset;
   logic          cpu_read;
   logic [31:0]   pc;
   logic [31:0]   instruction, instruction2;
   logic          cpu_busywait, cpu_busywait2;
   logic          mem_read, mem_read2;
   logic [27:0]   mem_address, mem_address2;
   logic [127:0]  mem_readdata;
   logic          mem_busywait;
   logic [15:0]   miss_count;
   logic [1:0]    miss_count2;

   int checks   = 0;
   int failures = 0;

   // reference model: per-index valid/tag and a miss tally
   bit          m_valid [8];
   logic [24:0] m_tag   [8];
   int          m_miss;

   // memory model state
   int next_lat;
   int remaining;
   bit active;

   instruction_cache_controller #(.MISS_CNT_W(16)) dut (
      .clock(clock), .reset(reset), .cpu_read(cpu_read), .pc(pc),
      .instruction(instruction), .cpu_busywait(cpu_busywait),
      .mem_read(mem_read), .mem_address(mem_address),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
      .miss_count(miss_count));

   instruction_cache_controller #(.MISS_CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .cpu_read(cpu_read), .pc(pc),
      .instruction(instruction2), .cpu_busywait(cpu_busywait2),
      .mem_read(mem_read2), .mem_address(mem_address2),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
      .miss_count(miss_count2));

   always #5 clock = ~clock;

   function automatic logic [127:0] blk(input logic [27:0] a);
      logic [127:0] b;
      if (a == 28'h0) return {32'h0000001C, 32'h0000000B, 32'h0000000A, 32'h00000009};
      for (int w = 0; w < 4; w++) b[32*w +: 32] = {a, w[1:0], 2'b11} ^ 32'h5A5A0000;
      return b;
   endfunction

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [127:0] b;
      b = blk(a[31:4]);
      return b[32*a[3:2] +: 32];
   endfunction

   function automatic int sat2(input int n);
      return (n > 3) ? 3 : n;
   endfunction

   // Block memory: busy for next_lat cycles after seeing a new read, then delivers.
   always @(negedge clock) begin
      mem_readdata = blk(mem_address);
      if (mem_read) begin
         if (!active) begin
            active    = 1'b1;
            remaining = next_lat;
         end
         mem_busywait = (remaining > 0);
         if (remaining > 0) remaining--;
      end else begin
         active       = 1'b0;
         mem_busywait = 1'b0;
      end
   end

   task automatic model_clear();
      for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
      m_miss = 0;
   endtask

   // Present one fetch at a negedge; returns at a negedge once served.
   task automatic fetch(input logic [31:0] a, input int lat);
      int idx;
      int cyc;
      bit hit_exp;
      idx      = int'(a[6:4]);
      next_lat = lat;
      cpu_read = 1'b1;
      pc       = a;
      #1;
      hit_exp = m_valid[idx] && (m_tag[idx] == a[31:7]);
      if (hit_exp) begin
         checks++;
         if (cpu_busywait !== 1'b0 || instruction !== memword(a) || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL hit pc=%h got busy=%b instr=%h mem_read=%b exp busy=0 instr=%h mem_read=0",
                     a, cpu_busywait, instruction, mem_read, memword(a));
         end
      end else begin
         checks++;
         if (cpu_busywait !== 1'b1 || instruction !== 32'h0) begin
            failures++;
            $display("FAIL miss_detect pc=%h got busy=%b instr=%h exp busy=1 instr=0",
                     a, cpu_busywait, instruction);
         end
         cyc = 0;
         while (cpu_busywait === 1'b1 && cyc < 40) begin
            @(negedge clock); #1;
            cyc++;
            if (cyc == 1) begin
               checks++;
               if (mem_read !== 1'b1 || mem_address !== a[31:4]) begin
                  failures++;
                  $display("FAIL mem_req pc=%h got mem_read=%b addr=%h exp mem_read=1 addr=%h",
                           a, mem_read, mem_address, a[31:4]);
               end
            end
         end
         m_miss++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = a[31:7];
         checks++;
         if (cyc != lat + 3) begin
            failures++;
            $display("FAIL stall_len pc=%h got %0d cycles exp %0d", a, cyc, lat + 3);
         end
         checks++;
         if (instruction !== memword(a) || miss_count !== 16'(m_miss) || miss_count2 !== 2'(sat2(m_miss))) begin
            failures++;
            $display("FAIL after_fill pc=%h got instr=%h cnt=%0d cnt2=%0d exp instr=%h cnt=%0d cnt2=%0d",
                     a, instruction, miss_count, miss_count2, memword(a), m_miss, sat2(m_miss));
         end
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_read = 1'b1; pc = 32'h0; next_lat = 0;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (mem_read !== 1'b0 || mem_address !== 28'h0 || miss_count !== 16'h0 ||
          cpu_busywait !== 1'b1 || instruction !== 32'h0) begin
         failures++;
         $display("FAIL reset got mem_read=%b addr=%h cnt=%0d busy=%b instr=%h exp 0 0 0 1 0",
                  mem_read, mem_address, miss_count, cpu_busywait, instruction);
      end
      cpu_read = 1'b0; #1;
      checks++;
      if (cpu_busywait !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle_busy got %b exp 0", cpu_busywait);
      end
      @(negedge clock);
      reset = 1'b0;
      model_clear();
      @(negedge clock);
   endtask

   task automatic test_cold_miss();
      fetch(32'h00000008, 2);
      checks++;
      if (instruction !== 32'h0000000B || miss_count !== 16'd1) begin
         failures++;
         $display("FAIL cold_miss got instr=%h cnt=%0d exp instr=0000000b cnt=1", instruction, miss_count);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [3];
      logic [31:0] exp [3];
      pcs = '{32'h0, 32'h4, 32'hC};
      exp = '{32'h00000009, 32'h0000000A, 32'h0000001C};
      for (int i = 0; i < 3; i++) begin
         cpu_read = 1'b1; pc = pcs[i]; #1;
         checks++;
         if (instruction !== exp[i] || cpu_busywait !== 1'b0 || mem_read !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hit pc=%h got instr=%h busy=%b mem_read=%b exp instr=%h busy=0 mem_read=0",
                     pcs[i], instruction, cpu_busywait, mem_read, exp[i]);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_conflict();
      fetch(32'h00000080, 1);
      checks++;
      if (miss_count !== 16'd2) begin
         failures++;
         $display("FAIL conflict_cnt got %0d exp 2", miss_count);
      end
      fetch(32'h00000000, 0);
      checks++;
      if (miss_count !== 16'd3 || miss_count2 !== 2'd3) begin
         failures++;
         $display("FAIL refetch_cnt got %0d/%0d exp 3/3", miss_count, miss_count2);
      end
   endtask

   task automatic test_reset_mid_fill();
      next_lat = 6; cpu_read = 1'b1; pc = 32'h00000100;
      repeat (2) @(negedge clock);
      #1;
      checks++;
      if (mem_read !== 1'b1 || mem_busywait !== 1'b1) begin
         failures++;
         $display("FAIL midfill_setup got mem_read=%b busy=%b exp 1 1", mem_read, mem_busywait);
      end
      reset = 1'b1;
      @(negedge clock); #1;
      checks++;
      if (mem_read !== 1'b0 || miss_count !== 16'h0 || miss_count2 !== 2'h0 || cpu_busywait !== 1'b1) begin
         failures++;
         $display("FAIL midfill_reset got mem_read=%b cnt=%0d cnt2=%0d busy=%b exp 0 0 0 1",
                  mem_read, miss_count, miss_count2, cpu_busywait);
      end
      reset = 1'b0; cpu_read = 1'b0;
      model_clear();
      @(negedge clock);
      fetch(32'h00000000, 1);
      fetch(32'h00000100, 0);
   endtask

   task automatic test_pc_change();
      int cyc;
      next_lat = 3; cpu_read = 1'b1; pc = 32'h00000010;
      @(negedge clock);
      pc = 32'h00000040;
      cyc = 0;
      while (mem_read === 1'b1 && cyc < 20) begin
         #1;
         checks++;
         if (mem_address !== 28'h0000001) begin
            failures++;
            $display("FAIL pc_change_addr got %h exp 0000001", mem_address);
         end
         @(negedge clock);
         cyc++;
      end
      checks++;
      if (cyc != 4) begin
         failures++;
         $display("FAIL pc_change_len got %0d exp 4", cyc);
      end
      m_valid[1] = 1'b1; m_tag[1] = 25'h0; m_miss++;
      @(negedge clock);
      fetch(32'h00000040, 2);
      fetch(32'h00000014, 0);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 6; i++) begin
         cpu_read = 1'b0; pc = $urandom; #1;
         checks++;
         if (cpu_busywait !== 1'b0 || mem_read !== 1'b0 || instruction !== 32'h0) begin
            failures++;
            $display("FAIL idle pc=%h got busy=%b mem_read=%b instr=%h exp 0 0 0",
                     pc, cpu_busywait, mem_read, instruction);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int i = 0; i < 80; i++) begin
         a = {23'h0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
         if (($urandom & 32'h7) == 0) begin
            cpu_read = 1'b0; pc = $urandom;
            @(negedge clock);
         end
         fetch(a, int'($urandom_range(0, 3)));
      end
      checks++;
      if (miss_count2 !== 2'd3 || miss_count !== 16'(m_miss)) begin
         failures++;
         $display("FAIL saturation got cnt=%0d cnt2=%0d exp cnt=%0d cnt2=3", miss_count, miss_count2, m_miss);
      end
   endtask

   initial begin
      reset = 1'b1; cpu_read = 1'b0; pc = 32'h0;
      mem_busywait = 1'b0; mem_readdata = '0;
      remaining = 0; active = 1'b0; next_lat = 0;
      model_clear();
      @(negedge clock);
      test_reset();
      test_cold_miss();
      test_back_to_back();
      test_conflict();
      test_reset_mid_fill();
      test_pc_change();
      test_idle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/instruction_cache_controller.md
# instruction_cache_controller

Direct-mapped, read-only instruction cache and refill controller between the pipeline's fetch stage and the 128-bit-block `instruction_memory`. It serves 32-bit instruction fetches from 8 cached 16-byte lines and stalls the pipeline with `cpu_busywait` on a miss. On a miss it sequences a single block read from instruction memory through that memory's `read`/`busywait` handshake, then installs the line. It also keeps a saturating miss counter for performance measurement.

## Interface
Parameters:
- `MISS_CNT_W`, 16: width of the miss counter.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_read`  in  1  fetch request from the IF stage.
- `pc`  in  32  fetch byte address.
  - `pc[31:7]`: tag.
  - `pc[6:4]`: index.
  - `pc[3:2]`: word select.
  - `pc[1:0]`: ignored.
- `instruction`  out  32  fetched instruction word.
- `cpu_busywait`  out  1  stall request to the pipeline.
- `mem_read`  out  1  read request to instruction memory; registered.
- `mem_address`  out  28  block address to instruction memory; registered; equals the latched `pc[31:4]`.
- `mem_readdata`  in  128  block data from instruction memory. Byte k of the block is `[8k+7:8k]`.
- `mem_busywait`  in  1  memory busy; may rise combinationally with `mem_read`.
- `miss_count`  out  `MISS_CNT_W`  number of misses since reset; saturating.

## Operation
Storage: 8 lines. Each line holds a valid bit, a 25-bit tag and 128 bits of data. Only the valid bits and `miss_count` are reset; tags and data are not.

Hit detection is combinational:
- hit = `cpu_read` & valid[index] & (tag[index] == `pc[31:7]`).
- `instruction` = data[index] word `pc[3:2]` when hit, else 32'h0. Word w is data bits `[32w+31:32w]`.
- `cpu_busywait` = `cpu_read` & (state != IDLE, or miss).

FSM states are IDLE, MEM_READ and UPDATE.

IDLE:
- Entered on reset; `mem_read` is 0.
- On a clock edge with `cpu_read` & miss:
  - latch `pc[31:4]` into `mem_address`;
  - set `mem_read` = 1;
  - increment `miss_count`, saturating at all-ones;
  - go to MEM_READ.
- Otherwise stay in IDLE.

MEM_READ:
- Hold `mem_read` = 1 and `mem_address` stable.
- On a rising edge with `mem_busywait` = 0: capture `mem_readdata` into a fill register, clear `mem_read`, go to UPDATE.
- While `mem_busywait` = 1: stay in MEM_READ.

UPDATE:
- Write data[idx] = fill register, tag[idx] = latched address `[27:3]`, valid[idx] = 1, where idx = latched address `[2:0]`.
- Go to IDLE.

Fill behaviour:
- The fill always uses the latched address. A `pc` change or `cpu_read` drop during MEM_READ/UPDATE does not abort or redirect the fill.
- Only one outstanding miss exists at any time; there is no prefetch.
- A fill evicts whatever line occupies the index. No write-back is needed.

## Timing
Reset values:
- state = IDLE.
- `mem_read` = 0, `mem_address` = 0.
- all valid bits = 0.
- `miss_count` = 0.
- `cpu_busywait` = `cpu_read`, since every access misses after reset.

Hit latency:
- 0 cycles: `instruction` is valid combinationally in the same cycle.
- `cpu_busywait` stays 0; back-to-back hits sustain one fetch per cycle.

Miss latency:
- `cpu_busywait` rises in the same cycle the miss is presented.
- Edge 1: IDLE→MEM_READ.
- Edge 1+N: MEM_READ→UPDATE, where N ≥ 1 is the number of edges until `mem_busywait` is sampled low.
- Edge 2+N: UPDATE→IDLE.
- After edge 2+N the access hits and `cpu_busywait` drops. Stall = N+2 cycles.

Reset during MEM_READ or UPDATE:
- On that edge: state = IDLE, `mem_read` = 0, all valid = 0, `miss_count` = 0.
- A partial fill is never installed.

`mem_busywait` already low at the first MEM_READ edge: the data is accepted (N = 1).

## Test plan
- Cold miss:
  - Stimulus: reset, then `cpu_read`=1, `pc`=0x00000008, memory returns 128'h…_0000001C_0000000B_0000000A_00000009.
  - Required: `cpu_busywait`=1 immediately; `mem_read`=1 with `mem_address`=0x0000000; after fill, `instruction`=0x0000000B, `cpu_busywait`=0, `miss_count`=1.
- Same-block hits:
  - Stimulus: after the fill, `pc`=0x0, 0x4, 0xC on consecutive cycles.
  - Required: `instruction` = 0x00000009, 0x0000000A, 0x0000001C; `cpu_busywait`=0 throughout; `mem_read` stays 0.
- Conflict miss:
  - Stimulus: `pc`=0x00000080 (same index 0, tag 1).
  - Required: new fill with `mem_address`=0x0000008, `miss_count`=2; re-fetching `pc`=0x0 then misses again (`miss_count`=3).
- Reset mid-fill:
  - Stimulus: assert `reset` for one edge while in MEM_READ with `mem_busywait`=1.
  - Required: `mem_read`=0 on the next cycle; state IDLE; `miss_count`=0; `pc`=0x0 then misses.
- PC change during stall:
  - Stimulus: miss at 0x00000010, then change `pc` to 0x00000040 during MEM_READ.
  - Required: `mem_address` stays 0x0000001; line 1 is filled; the request at 0x40 then misses with `mem_address`=0x0000004.
- Idle/saturation:
  - Stimulus: `cpu_read`=0 with arbitrary `pc`.
  - Required: no `mem_read`, `cpu_busywait`=0.
  - Stimulus: with `MISS_CNT_W`=2, four misses.
  - Required: `miss_count` holds 3.
